// File: rtl/cpu_pkg.sv
// Shared CPU execute-stage definitions: multiplier FSM states and sequencing constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_ITERS = 16;
  localparam int MUL_CNT_W = 5;

endpackage

// File: rtl/Adder_16bit.sv
// 16-bit combinational ripple-carry adder, carry-in tied low.
module Adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic        CarryOut
);

  logic [16:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign CarryOut = c[16];

endmodule

// File: rtl/mul16_seq.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier, one partial product per clock,
// built around a single shared 16-bit ripple adder.
module mul16_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [MUL_CNT_W-1:0] LAST_ITER = MUL_CNT_W'(MUL_ITERS - 1);

  mul_state_t           state, state_nxt;
  logic [WIDTH-1:0]     mcand, acc_hi, acc_lo;
  logic [WIDTH-1:0]     addend, sum;
  logic                 cout;
  logic [MUL_CNT_W-1:0] cnt;

  assign addend = acc_lo[0] ? mcand : '0;

  Adder_16bit u_add (
    .A        (acc_hi),
    .B        (addend),
    .Sum      (sum),
    .CarryOut (cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Carry-out rides in as the new MSB so the 17-bit partial sum is never truncated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= a;
          acc_hi <= '0;
          acc_lo <= b;
          cnt    <= '0;
        end
        CALC: begin
          {acc_hi, acc_lo} <= {cout, sum, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product = {acc_hi, acc_lo};

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed corner cases plus random back-to-back traffic
// compared against plain a*b arithmetic.
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        ready, busy, done;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;

  mul16_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One multiply; start accepted on the edge following the first negedge.
  // Sample k is taken k edges after that accepting edge: done belongs at k=16
  // (the 17th cycle counting the accepting one), IDLE again at k=17.
  // g1/g2 name sample points where a spurious start with junk operands is driven.
  task automatic mul_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input int g1, input int g2);
    logic [31:0] exp, at_done;
    int lat, ndone;
    exp     = 32'(x) * 32'(y);
    at_done = 'x;
    lat     = -1;
    ndone   = 0;
    @(negedge clk);
    chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat     = k;
          at_done = product;
        end
      end
      start = (k == g1 || k == g2);
      if (start) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd16);
    chk({tag, "_ndone"}, 32'(ndone), 32'd1);
    chk({tag, "_prod_done"}, at_done, exp);
    chk({tag, "_prod_held"}, product, exp);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] e;
    int ndone;
    logic exp_done;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", product, 32'h0);
    reset = 1'b0;

    mul_op("m3x5", 16'd3, 16'd5, 0, 0);
    mul_op("mffff", 16'hFFFF, 16'hFFFF, 0, 0);
    mul_op("m_b0", 16'h1234, 16'h0000, 0, 0);
    mul_op("m_a0", 16'h0000, 16'hABCD, 0, 0);
    mul_op("m8000x2", 16'h8000, 16'h0002, 0, 0);
    mul_op("m_ignore", 16'hBEEF, 16'h1357, 5, 10);

    // Abort mid-calculation: reset must act without waiting for an edge.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_product", product, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    mul_op("m7x9", 16'd7, 16'd9, 0, 0);

    // start held for 60 cycles: accepts every 18th edge, operands scrambled in between.
    for (int j = 0; j < 76; j++) begin
      @(negedge clk);
      exp_done = (j >= 17) && (j % 18 == 17);
      chk($sformatf("held_done_%0d", j), 32'(done), 32'(exp_done));
      if (exp_done) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        chk($sformatf("held_prod_%0d", j), product, e);
      end
      start = (j < 60);
      a = 16'($urandom);
      b = 16'($urandom);
      if (start && (j % 18 == 0)) q.push_back(32'(a) * 32'(b));
    end
    chk("held_queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
# mul16_seq

Multi-cycle unsigned 16x16 -> 32-bit multiplier controller for the CPU execute stage. Sequences the existing combinational 16-bit ripple adder `Adder_16bit` through a shift-and-add algorithm, one partial product per clock. The ALU issues `MUL` operands through a start/done handshake and stalls on `busy`.

## Interface
- `WIDTH`, default 16: operand width. Only 16 is supported because the adder datapath is fixed at 16 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high. Forces IDLE.
- `start` in 1: request a multiply. Sampled only while `ready`=1.
- `a` in 16: multiplicand, captured when start is accepted.
- `b` in 16: multiplier, captured when start is accepted.
- `ready` out 1: high in IDLE; the block can accept `start`.
- `busy` out 1: high in CALC and DONE.
- `done` out 1: one-cycle pulse in DONE; `product` is valid.
- `product` out 32: result `a*b`, held stable from DONE until the next accepted start.

## Operation
- Registers:
  - `mcand` (16): multiplicand.
  - `acc_hi` (16): upper accumulator half.
  - `acc_lo` (16): starts as the multiplier, ends as the low product half.
  - `cnt` (5): iteration counter.
  - `state`.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on `start`. Load `mcand`=`a`, `acc_hi`=0, `acc_lo`=`b`, `cnt`=0.
  - CALC -> CALC while `cnt` < 15.
  - CALC -> DONE on the edge that completes iteration `cnt`=15.
  - DONE -> IDLE unconditionally after one cycle.
- One CALC iteration, on each edge:
  - Adder inputs: A=`acc_hi`, B=`acc_lo[0]` ? `mcand` : 16'h0000.
  - Adder outputs: `sum`, `cout`.
  - Update `{acc_hi, acc_lo}` <= `{cout, sum, acc_lo[15:1]}`, a 33-bit value shifted right by 1.
  - `cnt` <= `cnt`+1.
- Width rule: the adder carry-out is the 17th bit of the partial sum and is never dropped. The 32-bit result is exact for all operand pairs; there is no overflow flag.
- `product` = `{acc_hi, acc_lo}`. It is driven combinationally from the registers and stays stable in IDLE after DONE.
- `start` while `busy` is ignored; operands are not recaptured.
- `start` held high continuously issues a new multiply each time IDLE is reached.
- Reset values:
  - `state`=IDLE, so `ready`=1, `busy`=0, `done`=0.
  - `product`=32'h0, `cnt`=0, `mcand`=0.
- Reset mid-operation aborts immediately and discards the partial result. `done` never pulses for the aborted operation.

## Timing
- Start accepted at edge T0 (`start`=1, `ready`=1). CALC occupies cycles T0+1..T0+16, 16 iterations.
- `done`=1 during cycle T0+17 only. Latency from start edge to `done` is 17 cycles.
- `ready`=1 again at T0+18. Earliest next accepted start is edge T0+18, giving a throughput of one multiply per 18 cycles.
- Critical path: the 16-bit ripple carry chain plus the operand mux and shift, within one clock.
- `ready` and `busy` are decoded from `state` only, with no combinational path from `start`.

## Structure
- Shared package `cpu_pkg`:
  - `mul_state_t` enum: IDLE, CALC, DONE.
  - `MUL_ITERS`=16.
  - `MUL_CNT_W`=5.
- The single sub-module is the existing `Adder_16bit`, instantiated once: A=`acc_hi`, B=gated `mcand`, result=`sum`, CarryOut=`cout`.
- No other hierarchy. The FSM, counter and shift register live in `mul16_seq`.

## Test plan
- Reset released, then `a`=3, `b`=5, `start` 1 cycle -> `done` pulses exactly 17 cycles after the start edge; `product`=32'h0000000F; `ready`=1 one cycle later.
- `a`=16'hFFFF, `b`=16'hFFFF -> `product`=32'hFFFE0001. This checks carry-out propagation on every iteration.
- `a`=16'h1234, `b`=0, then `a`=0, `b`=16'hABCD -> `product`=0 both times, `done` timing unchanged. Then `a`=16'h8000, `b`=2 -> `product`=32'h00010000.
- `start` pulsed with new operands at cycles 5 and 10 of CALC -> ignored; the original product completes on schedule and `done` pulses once.
- `reset` asserted at CALC cycle 8 -> IDLE, `product`=0, `busy`=0 asynchronously. No `done` follows. A fresh start of 7*9 then gives `product`=63.
- `start` held high for 60 cycles with random operands -> a `done` every 18 cycles, each `product` matching a reference model.
